// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer and its decoder.
// Opcode constants, state encoding, write-back / PC-select encodings, trap causes.
// No logic beyond a pure opcode-legality helper.
package rv32i_pkg;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Sequencer states; the numeric value is visible on the debug port
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_e;

  // Register write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Next-PC select
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  // True for the opcodes this sequencer knows how to run
  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE: opcode_legal = 1'b1;
      default:                                          opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_wait_timer.sv
// Memory wait timer: loadable up-counter with clear, enable and limit flag.
// hit is high while the count sits one below LIMIT, i.e. the next
// enabled cycle would reach LIMIT.
module rv32i_wait_timer #(
  parameter int LIMIT = 255,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         hit
);

  logic [W-1:0] count;

  // Count enabled cycles; clear and reset take priority over load and enable
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign hit = (count == W'(LIMIT - 1));

endmodule

// File: rtl/rv32i_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory, write-back.
// Outputs decode from state and latched IR; ir_load/pc_write follow acks the same cycle.
// Waits on imem_ack/dmem_ack up to MEM_TIMEOUT cycles, then traps until reset.
module rv32i_sequencer
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [31:0]        instruction,
  output logic               ir_load,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  input  logic               branch_taken,
  output logic               alu_src_b,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               pc_write,
  output logic [1:0]         pc_sel,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [COUNT_W-1:0] retired,
  output logic [2:0]         state
);

  state_e     cur;
  logic [6:0] ir_opcode;
  logic [4:0] ir_rd;
  logic       timer_en;
  logic       timer_hit;
  logic       retire;

  // Operand, immediate and register-index fields are consumed by the datapath, not here
  logic unused_ir_fields;
  assign unused_ir_fields = ^instruction[31:12];

  // Opcode class of the latched instruction
  logic is_load, is_store, is_op, is_branch, is_jal, is_jalr, is_lui, is_fence;
  assign is_load   = (ir_opcode == OPC_LOAD);
  assign is_store  = (ir_opcode == OPC_STORE);
  assign is_op     = (ir_opcode == OPC_OP);
  assign is_branch = (ir_opcode == OPC_BRANCH);
  assign is_jal    = (ir_opcode == OPC_JAL);
  assign is_jalr   = (ir_opcode == OPC_JALR);
  assign is_lui    = (ir_opcode == OPC_LUI);
  assign is_fence  = (ir_opcode == OPC_FENCE);

  // Count only cycles spent waiting for an ack; anything else restarts the count
  assign timer_en = ((cur == ST_FETCH) && !imem_ack) || ((cur == ST_MEM) && !dmem_ack);

  rv32i_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (16)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (!timer_en),
    .load       (1'b0),
    .load_value (16'd0),
    .enable     (timer_en),
    .hit        (timer_hit)
  );

  // An instruction retires exactly when it commits its PC update
  assign retire = pc_write;
  assign state  = cur;

  // Control outputs from state and latched IR; all held low while reset is asserted
  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    pc_write  = 1'b0;
    pc_sel    = PC_PLUS4;
    trap      = 1'b0;
    if (!rst) begin
      case (cur)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
        end
        ST_EXECUTE: begin
          alu_src_b = !(is_op || is_branch);
          if (is_branch) begin
            pc_write = 1'b1;
            pc_sel   = branch_taken ? PC_BRANCH : PC_PLUS4;
          end else if (is_fence) begin
            pc_write = 1'b1;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          pc_write = is_store && dmem_ack;
        end
        ST_WB: begin
          reg_write = (ir_rd != 5'd0);
          if (is_load)                wb_sel = WB_MEM;
          else if (is_jal || is_jalr) wb_sel = WB_PC4;
          else if (is_lui)            wb_sel = WB_IMM;
          pc_write = 1'b1;
          if (is_jal)       pc_sel = PC_BRANCH;
          else if (is_jalr) pc_sel = PC_JALR;
        end
        ST_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

  // State transitions, IR latch, trap cause and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= ST_FETCH;
      ir_opcode  <= 7'd0;
      ir_rd      <= 5'd0;
      trap_cause <= CAUSE_NONE;
      retired    <= '0;
    end else begin
      if (retire) retired <= retired + COUNT_W'(1);
      case (cur)
        ST_FETCH: begin
          if (imem_ack) begin
            ir_opcode <= instruction[6:0];
            ir_rd     <= instruction[11:7];
            cur       <= ST_DECODE;
          end else if (timer_hit) begin
            trap_cause <= CAUSE_IMEM;
            cur        <= ST_TRAP;
          end
        end
        ST_DECODE: begin
          if (opcode_legal(ir_opcode)) begin
            cur <= ST_EXECUTE;
          end else begin
            trap_cause <= CAUSE_ILLEGAL;
            cur        <= ST_TRAP;
          end
        end
        ST_EXECUTE: begin
          if (is_load || is_store)       cur <= ST_MEM;
          else if (is_branch || is_fence) cur <= ST_FETCH;
          else                            cur <= ST_WB;
        end
        ST_MEM: begin
          if (dmem_ack) begin
            cur <= is_load ? ST_WB : ST_FETCH;
          end else if (timer_hit) begin
            trap_cause <= CAUSE_DMEM;
            cur        <= ST_TRAP;
          end
        end
        ST_WB:   cur <= ST_FETCH;
        ST_TRAP: cur <= ST_TRAP;
        default: cur <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: doc/rv32i_sequencer.md
# rv32i_sequencer

Multi-cycle control sequencer for the RV32I datapath. Drives instruction fetch, instruction-register load, ALU operand selection, data-memory access, register write-back and PC update as a state machine, one instruction at a time. Sits between the instruction/data memory handshakes and the datapath (decoder, register file, ALU, PC). Also keeps a retired-instruction counter and traps on illegal opcodes or memory timeouts.

## Interface
- MEM_TIMEOUT, 255, maximum wait cycles for imem_ack/dmem_ack before trap (1..65535)
- COUNT_W, 32, width of retire counter

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, held until imem_ack
- imem_ack  in  1  instruction valid this cycle
- instruction  in  32  fetched word
- ir_load  out  1  latch instruction into IR
- dmem_req  out  1  data access request, held until dmem_ack
- dmem_we  out  1  1 = store, 0 = load, valid with dmem_req
- dmem_ack  in  1  data access complete
- branch_taken  in  1  ALU compare result, sampled in EXECUTE
- alu_src_b  out  1  0 = rs2, 1 = immediate
- reg_write  out  1  register file write enable
- wb_sel  out  2  0 ALU, 1 memory, 2 PC+4, 3 immediate
- pc_write  out  1  PC update enable
- pc_sel  out  2  0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1
- trap  out  1  sticky, sequencer halted
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
- retired  out  COUNT_W  instructions completed
- state  out  3  current state, debug

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Reset state FETCH.
- FETCH: imem_req=1; on imem_ack: ir_load=1, -> DECODE.
- DECODE: classify IR[6:0]; legal = LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC, FENCE (NOP). Others -> TRAP, cause 1.
- EXECUTE: alu_src_b=1 for all but OP and BRANCH. LOAD/STORE -> MEM. BRANCH: pc_write=1, pc_sel=branch_taken?1:0, retire, -> FETCH. FENCE: pc_write=1, pc_sel=0, retire, -> FETCH. Else -> WB.
- MEM: dmem_req=1, dmem_we=(STORE). On dmem_ack: LOAD -> WB; STORE -> pc_write=1, pc_sel=0, retire, -> FETCH.
- WB: reg_write=1 unless IR[11:7]==0. wb_sel: LOAD 1, JAL/JALR 2, LUI 3, else 0. pc_write=1, pc_sel: JAL 1, JALR 2, else 0. Retire, -> FETCH.
- TRAP: all requests/enables 0; held until rst.
- Retire: retired+1 in the retiring cycle, wraps at 2^COUNT_W.

## Timing
- Reset values: all enables/requests 0, wb_sel/pc_sel 0, trap 0, trap_cause 0, retired 0, state FETCH. imem_req rises the first cycle after reset.
- Latency with zero-wait memory: OP/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH/FENCE 3, STORE 4, LOAD 5. Each memory wait cycle adds one.
- Outputs are Moore-decoded from state plus latched IR, except ir_load, pc_write and the transition on ack, which follow imem_ack/dmem_ack in the same cycle.
- Timeout counter clears on entering FETCH or MEM and increments each non-ack cycle. Reaching MEM_TIMEOUT -> TRAP, cause 2 or 3. An ack in the same cycle as the limit wins.
- Acks outside FETCH/MEM are ignored.
- rst mid-operation: next edge returns to FETCH, requests drop, retired cleared, trap cleared.

## Structure
- Shared package rv32i_pkg: opcode localparams, state enum, wb_sel/pc_sel encodings, trap_cause codes. The decoder uses the same opcode constants.
- One sub-module: rv32i_wait_timer, a loadable up-counter with clear, enable and a limit-hit flag.

## Test plan
- Reset, then ADD 0x007302B3 with imem_ack in the first cycle -> reg_write=1 and wb_sel=0 in cycle 4, pc_write with pc_sel=0, retired=1.
- LW with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0, wb_sel=1, total 8 cycles.
- BEQ with branch_taken=1, then 0 -> pc_sel 1 then 0 in EXECUTE. reg_write never asserts. Each branch takes 3 cycles.
- Opcode 0x7F -> trap=1, cause 1, in the cycle after DECODE. retired unchanged. Outputs stay quiet for 100 cycles.
- imem_ack withheld with MEM_TIMEOUT=4 -> trap with cause 2 after 4 wait cycles. An ack exactly at the limit instead proceeds to DECODE.
- rst asserted during MEM -> next cycle state FETCH, dmem_req 0, retired 0. A late dmem_ack is ignored.
